// File: rtl/axi4s_video_tpg.sv
// AXI4-Stream video test-pattern generator: solid, ramp, colour bars, checker.
// Emits H_ACTIVE x V_ACTIVE frames with tuser at SOF and tlast at EOL.
module axi4s_video_tpg #(
    parameter int DATA_WIDTH  = 12,
    parameter int TDATA_WIDTH = 16,
    parameter int H_ACTIVE    = 1920,
    parameter int V_ACTIVE    = 1080
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   aclken,
    input  logic                   enable,
    input  logic [1:0]             pattern_sel,
    input  logic [DATA_WIDTH-1:0]  solid_value,
    output logic [TDATA_WIDTH-1:0] m_axis_video_tdata,
    output logic                   m_axis_video_tvalid,
    input  logic                   m_axis_video_tready,
    output logic                   m_axis_video_tuser,
    output logic                   m_axis_video_tlast,
    output logic [15:0]            frame_count,
    output logic                   busy
);

    localparam int XW = 12;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [XW-1:0] H_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] V_LAST = XW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] B_LAST = XW'(BAR_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d, y_q, y_d;
    logic [XW-1:0]         bcnt_q, bcnt_d;
    logic [2:0]            bar_q, bar_d;
    logic [1:0]            pat_q, pat_d;
    logic [DATA_WIDTH-1:0] solid_q, solid_d;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic                  tuser_q, tuser_d;
    logic                  tlast_q, tlast_d;
    logic [15:0]           fcnt_q, fcnt_d;
    logic                  load, clear;

    // Pixel value for coordinates that will be presented next.
    function automatic logic [DATA_WIDTH-1:0] pix_f(
        input logic [XW-1:0]         x,
        input logic [XW-1:0]         y,
        input logic [2:0]            bar,
        input logic [1:0]            pat,
        input logic [DATA_WIDTH-1:0] sv
    );
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        unique case (pat)
            2'd0: p = sv;
            2'd1: p = DATA_WIDTH'(x);
            2'd2: p = {bar, (DATA_WIDTH-3)'(0)};
            2'd3: p = (x[3] ^ y[3]) ? '1 : '0;
        endcase
        return p;
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        bcnt_d  = bcnt_q;
        bar_d   = bar_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        fcnt_d  = fcnt_q;
        pix_d   = pix_q;
        tuser_d = tuser_q;
        tlast_d = tlast_q;
        load    = 1'b0;
        clear   = 1'b0;
        if (aclken) begin
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = ACTIVE;
                        pat_d   = pattern_sel;
                        solid_d = solid_value;
                        x_d     = '0;
                        y_d     = '0;
                        bcnt_d  = '0;
                        bar_d   = '0;
                        load    = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (m_axis_video_tready) begin
                        load = 1'b1;
                        if (x_q == H_LAST) begin
                            x_d    = '0;
                            bcnt_d = '0;
                            bar_d  = '0;
                            if (y_q == V_LAST) begin
                                y_d    = '0;
                                fcnt_d = fcnt_q + 16'd1;
                                if (enable) begin
                                    pat_d   = pattern_sel;
                                    solid_d = solid_value;
                                end else begin
                                    state_d = IDLE;
                                    load    = 1'b0;
                                    clear   = 1'b1;
                                end
                            end else begin
                                y_d = y_q + XW'(1);
                            end
                        end else begin
                            x_d = x_q + XW'(1);
                            // Bar 7 saturates and absorbs the remainder.
                            if (bar_q != 3'd7) begin
                                if (bcnt_q == B_LAST) begin
                                    bcnt_d = '0;
                                    bar_d  = bar_q + 3'd1;
                                end else begin
                                    bcnt_d = bcnt_q + XW'(1);
                                end
                            end
                        end
                    end
                end
            endcase
        end
        if (load) begin
            pix_d   = pix_f(x_d, y_d, bar_d, pat_d, solid_d);
            tuser_d = (x_d == '0) && (y_d == '0);
            tlast_d = (x_d == H_LAST);
        end
        if (clear) begin
            pix_d   = '0;
            tuser_d = 1'b0;
            tlast_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            bcnt_q  <= '0;
            bar_q   <= '0;
            pat_q   <= '0;
            solid_q <= '0;
            pix_q   <= '0;
            tuser_q <= 1'b0;
            tlast_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bcnt_q  <= bcnt_d;
            bar_q   <= bar_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            pix_q   <= pix_d;
            tuser_q <= tuser_d;
            tlast_q <= tlast_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign m_axis_video_tdata  = TDATA_WIDTH'(pix_q);
    assign m_axis_video_tvalid = (state_q == ACTIVE);
    assign m_axis_video_tuser  = tuser_q;
    assign m_axis_video_tlast  = tlast_q;
    assign frame_count         = fcnt_q;
    assign busy                = (state_q == ACTIVE);

endmodule

// File: doc/axi4s_video_tpg.md
Name: axi4s_video_tpg

Overview:
AXI4-Stream video test-pattern generator, the upstream stage of the video output bridge. Produces raster frames of H_ACTIVE x V_ACTIVE pixels on a master AXI4-Stream video interface (12-bit component in 16-bit tdata). Marks start of frame with tuser and end of line with tlast. Used for display bring-up without the VDMA path.

Parameters:
DATA_WIDTH, 12, pixel component width
TDATA_WIDTH, 16, tdata width; pixel is zero-extended into the LSBs
H_ACTIVE, 1920, active pixels per line (range 8..4095)
V_ACTIVE, 1080, active lines per frame (range 1..4095)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
aclken  in  1  clock enable; low freezes all state and outputs
enable  in  1  run request
pattern_sel  in  2  0 solid, 1 horizontal ramp, 2 colour bars, 3 checkerboard
solid_value  in  DATA_WIDTH  pixel value for the solid pattern
m_axis_video_tdata  out  TDATA_WIDTH  pixel
m_axis_video_tvalid  out  1  beat valid
m_axis_video_tready  in  1  downstream ready
m_axis_video_tuser  out  1  start of frame, pixel (0,0) only
m_axis_video_tlast  out  1  last pixel of the line (x = H_ACTIVE-1)
frame_count  out  16  completed frames, wraps at 0xFFFF -> 0
busy  out  1  high in ACTIVE

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; x = y = 0.
- All outputs are registered. Transfer = tvalid & tready & aclken. With aclken low, nothing changes.
- IDLE: on a cycle with aclken=1 and enable=1, latch pattern_sel and solid_value, then go to ACTIVE. On the next cycle tvalid=1 with pixel (0,0) and tuser=1.
- ACTIVE: tvalid stays high. tdata, tuser and tlast are held stable until a transfer occurs.
- On transfer:
  - x increments.
  - At x = H_ACTIVE-1, x wraps to 0 and y increments.
  - At the last pixel (H_ACTIVE-1, V_ACTIVE-1): frame_count increments and y wraps to 0.
    - If enable=1: re-latch pattern_sel and solid_value, and present (0,0) with tuser=1 on the next cycle. Back-to-back frames have no bubble.
    - If enable=0: go to IDLE; tvalid and busy drop on the next cycle.
- Deasserting enable mid-frame does not abort the frame; the frame always completes.
- pattern_sel and solid_value changes mid-frame are ignored until the next frame start.
- Pixel function (x, y are counters of the presented pixel; MAX = 2^DATA_WIDTH-1):
  - solid: latched solid_value.
  - ramp: x mod 2^DATA_WIDTH.
  - bars: BAR_W = H_ACTIVE/8 (integer division). b = min(x/BAR_W, 7). Pixel = b << (DATA_WIDTH-3). Bar 7 absorbs the remainder. No divider: a bar counter resets at line start and advances when the within-bar count reaches BAR_W-1, saturating at 7.
  - checker: (x[3] ^ y[3]) ? MAX : 0.
- tdata upper TDATA_WIDTH-DATA_WIDTH bits are always 0.
- Simultaneous transfer of the last pixel and enable falling in the same cycle: the frame counts, and the block goes to IDLE.
- Reset mid-frame: outputs clear immediately. The next run restarts at (0,0) with tuser.

Test Plan:
(Bench parameters: H_ACTIVE=16, V_ACTIVE=4, DATA_WIDTH=12, TDATA_WIDTH=16.)
1. Ramp, tready=1, enable pulsed once -> exactly 64 beats; tdata = 0..15 per line; tuser only on beat 0; tlast on beats 15/31/47/63; frame_count=1; tvalid/busy low after.
2. Ramp, random tready (~40%) and aclken toggling -> tdata/tuser/tlast never change while tvalid & !(tready & aclken); beat sequence identical to scenario 1.
3. Bars (BAR_W=2) -> each line tdata = 0,0,0x200,0x200,0x400,0x400, ... ,0xE00,0xE00.
4. Checkerboard -> each line x 0..7 = 0x000, x 8..15 = 0xFFF; tdata[15:12]=0.
5. Solid 0xABC with enable held high; switch pattern_sel to ramp at beat 20 -> frame 1 all 0xABC; frame 2 starts with no idle cycle (tuser on beat 64); frame 2 is ramp.
6. aresetn low at beat 10 -> tvalid/tuser/tlast/busy = 0 immediately; after release and enable, first beat is tdata=0, tuser=1; frame_count=0.
